// File: rtl/spi_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_burst_ctrl_if
//  Description : Host register bus and downstream spi master register port
//                bundled for spi_burst_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_burst_ctrl_if;
   // host side register bus
   logic [31:0] data_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic [31:0] data_o;
   // downstream spi master register port
   logic [31:0] m_data_o;
   logic [31:0] m_addr_o;
   logic        m_we_o;
   logic [31:0] m_data_i;

   // the burst controller itself
   modport slave (
      input  data_i, addr_i, we_i, m_data_i,
      output data_o, m_data_o, m_addr_o, m_we_o
   );

   // host plus spi master surroundings
   modport master (
      output data_i, addr_i, we_i, m_data_i,
      input  data_o, m_data_o, m_addr_o, m_we_o
   );
endinterface
`default_nettype wire

// File: rtl/spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_burst_ctrl
//  Description : Multi-byte SPI burst sequencer. Stages host bytes in an
//                8-deep TX FIFO, feeds the single-byte spi master one byte
//                at a time with SS held, and collects replies in an 8-deep
//                RX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_burst_ctrl (
   input  logic            clk_i,
   input  logic            rst_i,
   spi_burst_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_CAPTURE   = 3'd5,
      S_FINISH    = 3'd6
   } state_t;

   localparam logic [3:0] FIFO_DEPTH = 4'd8;

   state_t      state, state_nxt;
   logic        cpol, cpha, hold_cs;
   logic [7:0]  div;
   logic [3:0]  len, remaining;
   logic        abort_pend, rx_ovf, tx_ovf;
   logic [7:0]  tx_mem [8];
   logic [7:0]  rx_mem [8];
   logic [2:0]  tx_wp, tx_rp, rx_wp, rx_rp;
   logic [3:0]  tx_cnt, rx_cnt;

   logic ctrl_wr, tx_wr, stat_wr, rx_wr;
   logic start_req, abort_req, abort_any, busy;
   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
   logic unused_bits;

   assign ctrl_wr  = bus.we_i && (bus.addr_i[3:0] == 4'h0);
   assign tx_wr    = bus.we_i && (bus.addr_i[3:0] == 4'h4);
   assign stat_wr  = bus.we_i && (bus.addr_i[3:0] == 4'h8);
   assign rx_wr    = bus.we_i && (bus.addr_i[3:0] == 4'hC);

   assign busy      = (state != S_IDLE);
   assign start_req = ctrl_wr && !busy && bus.data_i[0] && (bus.data_i[19:16] != 4'h0);
   assign abort_req = ctrl_wr && busy && bus.data_i[31];
   // an abort seen in a wait state is remembered until the master goes idle
   assign abort_any = abort_req || abort_pend;

   assign tx_full  = (tx_cnt == FIFO_DEPTH);
   assign tx_empty = (tx_cnt == 4'h0);
   assign rx_full  = (rx_cnt == FIFO_DEPTH);
   assign rx_empty = (rx_cnt == 4'h0);

   assign tx_push     = tx_wr && !tx_full;
   assign tx_pop      = (state == S_LOAD) && !tx_empty;
   assign rx_push_req = (state == S_CAPTURE) && !abort_any;
   assign rx_push     = rx_push_req && !rx_full;
   assign rx_pop      = rx_wr && !rx_empty;

   assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[30:20], bus.m_data_i[31:8]};

   // state register; reset returns to idle even mid-burst
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state and master register port drive
   always_comb begin
      state_nxt    = state;
      bus.m_we_o   = 1'b0;
      bus.m_addr_o = 32'h8;
      bus.m_data_o = 32'h0;
      case (state)
         S_IDLE: begin
            if (start_req) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            bus.m_we_o   = 1'b1;
            bus.m_addr_o = 32'h4;
            bus.m_data_o = {24'h0, (tx_empty ? 8'h00 : tx_mem[tx_rp])};
            state_nxt    = abort_any ? S_FINISH : S_START;
         end
         S_START: begin
            // suppress the enable write on abort so FINISH is not a second
            // back-to-back CTRL write
            if (abort_any) begin
               state_nxt = S_FINISH;
            end else begin
               bus.m_we_o   = 1'b1;
               bus.m_addr_o = 32'h0;
               bus.m_data_o = {16'h0, div, 4'h0, 1'b1, cpha, cpol, 1'b1};
               state_nxt    = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (bus.m_data_i[0]) state_nxt = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (!bus.m_data_i[0]) state_nxt = abort_any ? S_FINISH : S_CAPTURE;
         end
         S_CAPTURE: begin
            bus.m_addr_o = 32'h4;
            state_nxt    = (abort_any || remaining == 4'd1) ? S_FINISH : S_LOAD;
         end
         S_FINISH: begin
            bus.m_we_o   = 1'b1;
            bus.m_addr_o = 32'h0;
            bus.m_data_o = {16'h0, div, 4'h0, hold_cs, cpha, cpol, 1'b0};
            state_nxt    = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // control fields, burst counter, abort latch and sticky overflow flags
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cpol       <= 1'b0;
         cpha       <= 1'b0;
         hold_cs    <= 1'b0;
         div        <= 8'h0;
         len        <= 4'h0;
         remaining  <= 4'h0;
         abort_pend <= 1'b0;
         rx_ovf     <= 1'b0;
         tx_ovf     <= 1'b0;
      end else begin
         if (ctrl_wr && !busy) begin
            cpol    <= bus.data_i[1];
            cpha    <= bus.data_i[2];
            hold_cs <= bus.data_i[3];
            div     <= bus.data_i[15:8];
            len     <= bus.data_i[19:16];
         end
         if (start_req)               remaining <= bus.data_i[19:16];
         else if (state == S_CAPTURE) remaining <= remaining - 4'd1;
         if (state == S_FINISH) abort_pend <= 1'b0;
         else if (abort_req)    abort_pend <= 1'b1;
         if (rx_push_req && rx_full)         rx_ovf <= 1'b1;
         else if (stat_wr && bus.data_i[16]) rx_ovf <= 1'b0;
         if (tx_wr && tx_full)               tx_ovf <= 1'b1;
         else if (stat_wr && bus.data_i[17]) tx_ovf <= 1'b0;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tx_wp  <= 3'h0;
         tx_rp  <= 3'h0;
         tx_cnt <= 4'h0;
         rx_wp  <= 3'h0;
         rx_rp  <= 3'h0;
         rx_cnt <= 4'h0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 3'd1;
         if (tx_pop)  tx_rp <= tx_rp + 3'd1;
         tx_cnt <= tx_cnt + {3'h0, tx_push} - {3'h0, tx_pop};
         if (rx_push) rx_wp <= rx_wp + 3'd1;
         if (rx_pop)  rx_rp <= rx_rp + 3'd1;
         rx_cnt <= rx_cnt + {3'h0, rx_push} - {3'h0, rx_pop};
      end
   end

   // FIFO storage
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wp] <= bus.data_i[7:0];
      if (rx_push) rx_mem[rx_wp] <= bus.m_data_i[7:0];
   end

   // host read mux
   always_comb begin
      bus.data_o = 32'h0;
      case (bus.addr_i[3:0])
         4'h0: bus.data_o = {12'h0, len, div, 4'h0, hold_cs, cpha, cpol, 1'b0};
         4'h8: bus.data_o = {14'h0, tx_ovf, rx_ovf, rx_cnt, tx_cnt, 3'h0,
                             rx_empty, rx_full, tx_empty, tx_full, busy};
         4'hC: bus.data_o = {24'h0, (rx_empty ? 8'h00 : rx_mem[rx_rp])};
         default: bus.data_o = 32'h0;
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_burst_ctrl
//  Description : Directed self-checking bench for spi_burst_ctrl with a
//                behavioural single-byte spi master on the register port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_burst_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   spi_burst_ctrl_if bus ();

   spi_burst_ctrl dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // spi master model: CTRL at 0x0, DATA at 0x4, STATUS (busy) at 0x8
   logic [31:0] mctrl;
   logic [7:0]  mtx, mrx;
   logic        mbusy, dly, prev_ctrl;
   logic        b2b = 1'b0;
   logic        loopback = 1'b1;
   int          cnt;
   int          nlog = 0;
   logic [7:0]  mosi_log [64];

   assign bus.m_data_i = (bus.m_addr_o[3:0] == 4'h0) ? mctrl :
                         (bus.m_addr_o[3:0] == 4'h4) ? {24'h0, mrx} : {31'h0, mbusy};

   // master model: busy visible two cycles after an enabling CTRL write
   always @(posedge clk) begin
      if (rst) begin
         mctrl <= 32'h0; mtx <= 8'h0; mrx <= 8'h0; mbusy <= 1'b0;
         dly <= 1'b0; cnt <= 0; prev_ctrl <= 1'b0;
      end else begin
         prev_ctrl <= bus.m_we_o && (bus.m_addr_o == 32'h0);
         if (bus.m_we_o && (bus.m_addr_o == 32'h0) && prev_ctrl) b2b <= 1'b1;
         if (bus.m_we_o && (bus.m_addr_o == 32'h4)) mtx <= bus.m_data_o[7:0];
         if (bus.m_we_o && (bus.m_addr_o == 32'h0)) mctrl <= bus.m_data_o;
         dly <= bus.m_we_o && (bus.m_addr_o == 32'h0) && bus.m_data_o[0];
         if (dly) begin
            mbusy <= 1'b1;
            cnt <= 9;
            mosi_log[nlog] <= mtx;
            nlog <= nlog + 1;
         end else if (mbusy) begin
            if (cnt == 0) begin
               mbusy <= 1'b0;
               mrx <= loopback ? mtx : 8'h5A;
            end else begin
               cnt <= cnt - 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr_i = a; bus.data_i = d; bus.we_i = 1'b1;
      @(negedge clk);
      bus.we_i = 1'b0; bus.data_i = 32'h0;
   endtask

   task automatic host_read(input logic [31:0] a, output logic [31:0] d);
      bus.addr_i = a;
      #1;
      d = bus.data_o;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] s;
      int n;
      n = 0;
      s = 32'h1;
      while (s[0] && n < 3000) begin
         @(negedge clk);
         host_read(32'h8, s);
         n++;
      end
      if (s[0]) begin
         checks++; errors++;
         $error("FAIL %s observed=busy expected=idle (timeout)", tag);
      end
   endtask

   task automatic wait_master_busy(input string tag, input int min_log);
      int n;
      n = 0;
      while (!(mbusy && nlog >= min_log) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!(mbusy && nlog >= min_log)) begin
         checks++; errors++;
         $error("FAIL %s observed=master idle expected=master busy (timeout)", tag);
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] cw;
      logic [1:0]  mm;
      int          base;
      bus.we_i = 1'b0; bus.addr_i = 32'h0; bus.data_i = 32'h0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_m_we", {31'h0, bus.m_we_o}, 32'h0);
      chk("rst_m_addr", bus.m_addr_o, 32'h8);
      chk("rst_m_data", bus.m_data_o, 32'h0);
      chk("rst_data_o", bus.data_o, 32'h0);
      host_read(32'h8, r); chk("rst_status", r, 32'h14);
      host_read(32'hC, r); chk("rst_rxdata", r, 32'h0);

      // ---------------- 3-byte loopback ----------------
      loopback = 1'b1;
      host_write(32'h4, 32'hA5);
      host_write(32'h4, 32'h3C);
      host_write(32'h4, 32'hFF);
      host_read(32'h8, r); chk("lb_status_pre", r, 32'h310);
      host_write(32'h0, 32'h0003_0001);
      host_read(32'h8, r); chk("lb_status_load", r, 32'h311);
      chk("lb_load_we", {31'h0, bus.m_we_o}, 32'h1);
      chk("lb_load_addr", bus.m_addr_o, 32'h4);
      chk("lb_load_data", bus.m_data_o, 32'hA5);
      @(negedge clk); #1;
      chk("lb_start_data", bus.m_data_o, 32'h9);
      wait_idle("lb_idle");
      chk("lb_ss_released", mctrl, 32'h0);
      host_read(32'h8, r); chk("lb_status_post", r, 32'h3004);
      host_read(32'hC, r); chk("lb_rx0", r, 32'hA5);
      host_write(32'hC, 32'h0);
      host_read(32'hC, r); chk("lb_rx1", r, 32'h3C);
      host_write(32'hC, 32'h0);
      host_read(32'hC, r); chk("lb_rx2", r, 32'hFF);
      host_write(32'hC, 32'h0);
      host_read(32'h8, r); chk("lb_status_drained", r, 32'h14);
      host_write(32'hC, 32'h0);
      host_read(32'h8, r); chk("lb_pop_empty", r, 32'h14);

      // ---------------- dummy read ----------------
      loopback = 1'b0;
      base = nlog;
      host_write(32'h0, 32'h0002_0001);
      wait_idle("dm_idle");
      chk("dm_nbytes", nlog - base, 2);
      chk("dm_mosi0", {24'h0, mosi_log[base]}, 32'h00);
      chk("dm_mosi1", {24'h0, mosi_log[base+1]}, 32'h00);
      host_read(32'h8, r); chk("dm_status", r, 32'h2004);
      host_read(32'hC, r); chk("dm_rx0", r, 32'h5A);
      host_write(32'hC, 32'h0);
      host_read(32'hC, r); chk("dm_rx1", r, 32'h5A);
      host_write(32'hC, 32'h0);

      // ---------------- overflow ----------------
      loopback = 1'b1;
      for (int i = 1; i <= 9; i++) host_write(32'h4, i);
      host_read(32'h8, r); chk("ov_tx_status", r, 32'h20812);
      host_write(32'h0, 32'h0008_0001);
      wait_idle("ov_idle1");
      host_write(32'h0, 32'h0008_0001);
      wait_idle("ov_idle2");
      host_read(32'h8, r); chk("ov_rx_status", r, 32'h3800C);
      host_read(32'hC, r); chk("ov_rx_head", r, 32'h01);
      host_write(32'h8, 32'h0003_0000);
      host_read(32'h8, r); chk("ov_sticky_clear", r, 32'h800C);
      for (int i = 0; i < 8; i++) host_write(32'hC, 32'h0);
      host_read(32'h8, r); chk("ov_drained", r, 32'h14);

      // ---------------- abort ----------------
      host_write(32'h4, 32'h11);
      host_write(32'h4, 32'h22);
      host_write(32'h4, 32'h33);
      host_write(32'h4, 32'h44);
      base = nlog;
      host_write(32'h0, 32'h0004_0001);
      wait_master_busy("ab_wait_byte2", base + 2);
      host_write(32'h0, 32'h8000_0000);
      wait_idle("ab_idle");
      host_read(32'h8, r); chk("ab_status", r, 32'h1200);
      host_read(32'hC, r); chk("ab_rx_head", r, 32'h11);
      chk("ab_finish_ctrl", mctrl, 32'h0);
      host_read(32'h0, r); chk("ab_ctrl_read", r, 32'h0004_0000);

      // ---------------- reset mid-burst (WAIT_DONE) ----------------
      base = nlog;
      host_write(32'h0, 32'h0002_0001);
      wait_master_busy("rs_wait", base + 1);
      rst = 1'b1;
      @(negedge clk); #1;
      chk("rs_m_we", {31'h0, bus.m_we_o}, 32'h0);
      chk("rs_m_addr", bus.m_addr_o, 32'h8);
      host_read(32'h8, r); chk("rs_status", r, 32'h14);
      rst = 1'b0;
      @(negedge clk); #1;
      host_read(32'h8, r); chk("rs_status_stay", r, 32'h14);

      // ---------------- hold_cs and all SPI modes ----------------
      loopback = 1'b0;
      for (int m = 0; m < 4; m++) begin
         mm = m[1:0];
         cw = {12'h0, 4'd1, 8'h02, 4'h0, 1'b1, mm[1], mm[0], 1'b1};
         host_write(32'h0, cw);
         host_write(32'h0, 32'h0007_0F06);
         host_read(32'h0, r); chk("md_ctrl_locked", r, cw & 32'hFFFF_FFFE);
         wait_idle("md_idle");
         chk("md_finish_ctrl", mctrl, {16'h0, 8'h02, 4'h0, 1'b1, mm[1], mm[0], 1'b0});
         host_read(32'hC, r); chk("md_rx", r, 32'h5A);
         host_write(32'hC, 32'h0);
      end

      chk("no_b2b_ctrl_writes", {31'h0, b2b}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/spi_burst_ctrl.md
# spi_burst_ctrl

Multi-byte SPI transfer sequencer that sits directly upstream of the single-byte `spi` master. It takes a burst descriptor and TX bytes from the core-side register bus and stages them in 8-entry TX/RX FIFOs. It then drives the `spi` master's register port (CTRL/DATA/STATUS) byte by byte, keeping chip-select asserted across the burst, and collects received bytes for software.

## Interface
- No parameters; FIFO depth fixed at 8 bytes each.
- `clk_i` in 1: single clock; also clocks the downstream `spi` master.
- `rst_i` in 1: synchronous, active-high reset.
- `data_i` in 32: host write data.
- `addr_i` in 32: host address; only `[3:0]` decoded.
- `we_i` in 1: host write strobe, one cycle per write.
- `data_o` out 32: host read data, combinational from `addr_i[3:0]`.
- `m_data_o` out 32: to `spi.data_i`.
- `m_addr_o` out 32: to `spi.addr_i`.
- `m_we_o` out 1: to `spi.we_i`.
- `m_data_i` in 32: from `spi.data_o`.

## Operation
Host register map:
- 0x0 CTRL (RW).
  - [0] start: write-1, self-clearing, reads 0.
  - [1] CPOL, [2] CPHA.
  - [3] hold_cs: keep SS asserted after the burst.
  - [15:8] div.
  - [19:16] len, 1..8 bytes.
  - [31] abort: write-1, reads 0.
- 0x4 TXDATA (W): push `data_i[7:0]` into TX FIFO. Reads 0.
- 0x8 STATUS (R).
  - [0] busy, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty.
  - [11:8] tx_count, [15:12] rx_count (0..8, 4 bits).
  - [16] rx_ovf, [17] tx_ovf: sticky; writing 1 to the matching STATUS bit clears it.
- 0xC RXDATA.
  - Read: RX head byte in [7:0], 0 if empty.
  - Any write: pop head; no effect if empty.

Rules:
- While busy, CTRL writes are ignored except bit 31.
- A start with len=0 is ignored.
- A TX push when full is dropped and sets tx_ovf.
- Simultaneous push and pop on the same FIFO: count unchanged, both take effect.

FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, CAPTURE, FINISH.
- IDLE: master port shows `m_addr_o=0x8`, `m_we_o=0`, `m_data_o=0`.
  - Start with len≠0 → latch CPOL/CPHA/div/hold_cs, set remaining = len → LOAD.
- LOAD (1 cycle): `m_we_o=1`, `m_addr_o=0x4`, `m_data_o={24'h0, byte}`.
  - byte = TX head (popped), or 0x00 if TX is empty. A short TX FIFO means dummy read bytes.
  - → START.
- START (1 cycle): `m_we_o=1`, `m_addr_o=0x0`, `m_data_o={16'h0, div, 4'h0, 1'b1, CPHA, CPOL, 1'b1}`.
  - Bit 3 asserts SS; bit 0 enables the master.
  - → WAIT_BUSY.
- WAIT_BUSY: `m_we_o=0`, `m_addr_o=0x8`. Stay until `m_data_i[0]==1` → WAIT_DONE.
- WAIT_DONE: same outputs. Stay until `m_data_i[0]==0` → CAPTURE.
- CAPTURE (1 cycle): `m_addr_o=0x4`. Push `m_data_i[7:0]` into RX; if RX is full, drop the byte and set rx_ovf.
  - Decrement remaining; → LOAD if remaining≠0, else FINISH.
- FINISH (1 cycle): `m_we_o=1`, `m_addr_o=0x0`, `m_data_o={16'h0, div, 4'h0, hold_cs, CPHA, CPOL, 1'b0}` → IDLE.

Abort write:
- From LOAD/START/CAPTURE → FINISH next cycle. Any byte already in flight is not captured.
- From WAIT_BUSY/WAIT_DONE → wait for busy to drop, then FINISH without capture. This prevents a master re-trigger.

busy = (state ≠ IDLE).

## Timing
- Reset values:
  - `m_we_o=0`, `m_addr_o=0x8`, `m_data_o=0`, `data_o=0`.
  - state IDLE, FIFOs empty, CTRL/sticky bits 0.
- Reset mid-burst: immediate return to IDLE. The master is reset by the same system reset.
- Start write at cycle N → LOAD at N+1, START at N+2.
- `m_we_o` is never high for two consecutive cycles into CTRL, so the master's self-clearing enable bit drops.
- The master reports busy 2 cycles after the START write. WAIT_BUSY must tolerate any delay.
- Per-byte overhead beyond the SPI shift time: LOAD + START + WAIT_BUSY (≥2) + CAPTURE.
- STATUS busy=0 implies the master's DATA register already holds the received byte.
- Host `data_o` reflects FIFO and STATUS state registered at the preceding edge.

## Test plan
- Reset:
  - Assert rst_i during WAIT_DONE → next cycle state IDLE, `m_we_o=0`, `m_addr_o=0x8`, STATUS=0x14.
- 3-byte loopback:
  - Setup: miso tied to mosi; CPOL=0, CPHA=0, div=0.
  - Push 0xA5, 0x3C, 0xFF; start len=3.
  - Required: RX pops 0xA5, 0x3C, 0xFF; SS low throughout, high after FINISH; busy clears.
- Dummy read:
  - Setup: TX empty, slave model returns 0x5A per byte.
  - Start len=2 → mosi 0x00, 0x00; RX = 0x5A, 0x5A.
- Overflow:
  - Push 9 TX bytes → tx_count=8, tx_ovf=1.
  - Start len=8 twice without popping → rx_count=8, rx_ovf=1.
  - Write STATUS 0x30000 → both sticky bits clear.
- Abort:
  - Start len=4; write CTRL bit31 during the 2nd byte's WAIT_DONE.
  - Required: exactly 1 RX byte captured; FINISH writes CTRL with bit0=0; busy=0.
- hold_cs and modes:
  - Run all four CPOL/CPHA combinations with hold_cs=1, len=1.
  - Required: SS stays low after the burst; spi_clk idles at CPOL; CTRL writes while busy are ignored.
